// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path and the future uart_tx.
//   - DATA_BITS                       : payload width of one character
//   - DEFAULT_CLK_FREQ_HZ/_BAUD_RATE  : board defaults (12 MHz core, 115200 baud)
//   - rx_state_e                      : receive FSM state encoding
package uart_pkg;

  localparam int DATA_BITS           = 8;
  localparam int DEFAULT_CLK_FREQ_HZ = 12_000_000;
  localparam int DEFAULT_BAUD_RATE   = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,  // reachable only when UART_RX_PARITY_EN is defined
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input.
//   clk       in   destination clock
//   rst_n     in   asynchronous active-low reset
//   d         in   asynchronous input
//   q         out  synchronised output (two clk cycles of latency)
// RESET_VAL sets the value both flops take in reset, so an idle-high line
// does not look like an edge when reset is released.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: serial receive front end (8N1, optional even parity).
//   CLK_I         in   core clock
//   RST_N_I       in   asynchronous active-low reset
//   RX_I          in   raw serial line, asynchronous, idle high
//   DATA_O        out  received byte (LSB first on the wire)
//   VALID_O       out  DATA_O holds an unconsumed byte
//   READY_I       in   consumer takes DATA_O when VALID_O && READY_I
//   FRAME_ERR_O   out  one-cycle pulse: stop bit sampled low
//   OVERRUN_O     out  one-cycle pulse: completed byte dropped, slot full
//   BUSY_O        out  high while the FSM is not in IDLE
//   PARITY_ERR_O  out  one-cycle pulse at completion on parity mismatch
//                      (port exists only with UART_RX_PARITY_EN)
// Build option: define UART_RX_PARITY_EN for an 11-bit frame with one even
// parity bit between the data bits and the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int BAUD_RATE   = DEFAULT_BAUD_RATE
) (
  input  logic                 CLK_I,
  input  logic                 RST_N_I,
  input  logic                 RX_I,
  output logic [DATA_BITS-1:0] DATA_O,
  output logic                 VALID_O,
  input  logic                 READY_I,
  output logic                 FRAME_ERR_O,
  output logic                 OVERRUN_O,
  output logic                 BUSY_O
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 PARITY_ERR_O
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT    = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 8) begin : g_cpb_check
    $error("uart_rx: CLK_FREQ_HZ/BAUD_RATE must be at least 8");
  end

  logic                 rxs;
  rx_state_e            state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 strobe;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (CLK_I),
    .rst_n (RST_N_I),
    .d     (RX_I),
    .q     (rxs)
  );

  // Sample point: the down-counter reaching zero. START loads half a bit so
  // every later strobe lands mid-bit.
  assign strobe = (cnt == '0);

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      // NOTE: the shift register is reset as well, so DATA_O can never load an X.
      shreg       <= '0;
      DATA_O      <= '0;
      VALID_O     <= 1'b0;
      FRAME_ERR_O <= 1'b0;
      OVERRUN_O   <= 1'b0;
      BUSY_O      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      PARITY_ERR_O <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking throughout: every branch sees pre-edge values, and a
      // later assignment in this block overrides an earlier default.
      FRAME_ERR_O <= 1'b0;
      OVERRUN_O   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      PARITY_ERR_O <= 1'b0;
`endif

      // Consumer handshake; a completion below may reload the slot instead.
      if (VALID_O && READY_I) VALID_O <= 1'b0;

      if (state != ST_IDLE) cnt <= strobe ? BIT_RELOAD : cnt - 1'b1;

      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            cnt    <= HALF_RELOAD;
            state  <= ST_START;
            BUSY_O <= 1'b1;
          end
        end

        ST_START: begin
          if (strobe) begin
            if (rxs) begin
              // Line went high again by mid start bit: treat as a glitch.
              state  <= ST_IDLE;
              BUSY_O <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
          end
        end

        ST_DATA: begin
          if (strobe) begin
            shreg[bit_idx] <= rxs;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (strobe) begin
            // Even parity: data bits plus parity bit hold an even number of ones.
            par_bad <= rxs ^ (^shreg);
            state   <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (strobe) begin
            if (rxs) begin
              // Slot is free if empty or being emptied in this same cycle.
              if (!VALID_O || READY_I) begin
                DATA_O  <= shreg;
                VALID_O <= 1'b1;
              end else begin
                OVERRUN_O <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              PARITY_ERR_O <= par_bad;
`endif
              state  <= ST_IDLE;
              BUSY_O <= 1'b0;
            end else begin
              FRAME_ERR_O <= 1'b1;
              state       <= ST_BREAK;
            end
          end
        end

        ST_BREAK: begin
          // A held-low line must return high before a new start bit counts.
          if (rxs) begin
            state  <= ST_IDLE;
            BUSY_O <= 1'b0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          BUSY_O <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at default parameters
// (12 MHz / 115200 -> 104 clocks per bit). Honours UART_RX_PARITY_EN.
// A frame-level model predicts, from the falling edge of each start bit,
// the cycle at which the byte completes and what the holding slot must then
// show; one monitor compares every cycle on the falling clock edge.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 104;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS   = 11;
  localparam int LATENCY_LIT  = 1095;  // 2 + 52 + 10*104 + 1
`else
  localparam int FRAME_BITS   = 10;
  localparam int LATENCY_LIT  = 991;   // 2 + 52 + 9*104 + 1
`endif
  // Clock edges from the start-bit falling edge until VALID_O is visible.
  localparam int LATENCY = 2 + CPB / 2 + (FRAME_BITS - 1) * CPB + 1;

  typedef struct {
    int         due;
    logic [7:0] data;
    bit         ok;
    bit         pbad;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overrun_o, busy_o;
  logic [11:0] dut_vec;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_fall = 0;

  // model state
  frame_t     pend[$];
  frame_t     cur;
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  logic       exp_ferr = 1'b0, exp_ovr = 1'b0, exp_perr = 1'b0;
  logic       rdy_prev = 1'b0;
  logic       v_before;

  // observed event counters
  int   ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0, rise_cnt = 0, valid_hi_cnt = 0;
  int   rise_cyc = 0;
  logic prev_valid = 1'b0;

`ifdef UART_RX_PARITY_EN
  logic parity_err_o;
  assign dut_vec = {valid_o, data_o, frame_err_o, overrun_o, parity_err_o};
`else
  assign dut_vec = {valid_o, data_o, frame_err_o, overrun_o, 1'b0};
`endif

  uart_rx dut (
    .CLK_I        (clk),
    .RST_N_I      (rst_n),
    .RX_I         (rx),
    .DATA_O       (data_o),
    .VALID_O      (valid_o),
    .READY_I      (ready),
    .FRAME_ERR_O  (frame_err_o),
    .OVERRUN_O    (overrun_o),
    .BUSY_O       (busy_o)
`ifdef UART_RX_PARITY_EN
    ,
    .PARITY_ERR_O (parity_err_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs change 2 ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit bad_par);
    frame_t f;
    logic   par;
    par       = (^b) ^ bad_par;
    rx        = 1'b0;
    last_fall = cyc;
    f.due     = cyc + LATENCY;
    f.data    = b;
    f.ok      = stop_bit;
    f.pbad    = (par != ^b);
    pend.push_back(f);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    tick(CPB);
`endif
    rx = stop_bit;
    tick(CPB);
  endtask

  // Model update and per-cycle compare.
  always @(negedge clk) begin
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    exp_perr = 1'b0;
    if (!rst_n) begin
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      pend.delete();
    end else begin
      v_before = exp_valid;
      if (v_before && rdy_prev) exp_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        cur = pend.pop_front();
        if (!cur.ok) begin
          exp_ferr = 1'b1;
        end else begin
          exp_perr = cur.pbad;
          if (!v_before || rdy_prev) begin
            exp_data  = cur.data;
            exp_valid = 1'b1;
          end else begin
            exp_ovr = 1'b1;
          end
        end
      end
    end
    check("outputs", dut_vec, {exp_valid, exp_data, exp_ferr, exp_ovr, exp_perr});

    if (frame_err_o) ferr_cnt++;
    if (overrun_o) ovr_cnt++;
    if (dut_vec[0]) perr_cnt++;
    if (valid_o) valid_hi_cnt++;
    if (valid_o && !prev_valid) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    prev_valid = valid_o;
    rdy_prev   = ready;
  end

  initial begin : stim
    int f0, o0, v0, r0, p0;

    tick(3);
    check("reset_vec", dut_vec, 12'h000);
    check("reset_busy", busy_o, 1'b0);
    rst_n = 1'b1;
    tick(5);

    // Clean byte, consumer always ready.
    ready = 1'b1;
    f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_hi_cnt;
    send_frame(8'h55, 1'b1, 1'b0);
    tick(20);
    check("t1_latency", rise_cyc - last_fall, LATENCY_LIT);
    check("t1_data", data_o, 8'h55);
    check("t1_valid_cycles", valid_hi_cnt - v0, 1);
    check("t1_no_ferr", ferr_cnt - f0, 0);
    check("t1_no_ovr", ovr_cnt - o0, 0);
    check("t1_busy_idle", busy_o, 1'b0);

    // Framing error followed by a held-low line.
    f0 = ferr_cnt; r0 = rise_cnt;
    send_frame(8'hA3, 1'b0, 1'b0);
    tick(300);
    check("t2_busy_break", busy_o, 1'b1);
    rx = 1'b1;
    tick(6);
    check("t2_busy_released", busy_o, 1'b0);
    check("t2_ferr_pulses", ferr_cnt - f0, 1);
    check("t2_no_valid", rise_cnt - r0, 0);

    // Start-bit glitch.
    f0 = ferr_cnt; r0 = rise_cnt;
    rx = 1'b0;
    tick(10);
    check("t3_busy_glitch", busy_o, 1'b1);
    tick(10);
    rx = 1'b1;
    tick(100);
    check("t3_busy_idle", busy_o, 1'b0);
    check("t3_no_ferr", ferr_cnt - f0, 0);
    check("t3_no_valid", rise_cnt - r0, 0);

    // Overrun: two bytes, consumer stalled.
    ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    tick(10);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(10);
    check("t4_held_data", data_o, 8'h11);
    check("t4_held_valid", valid_o, 1'b1);
    check("t4_ovr_pulses", ovr_cnt - o0, 1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(3);
    check("t4_consumed", valid_o, 1'b0);

    // Completion in the same cycle the pending byte is consumed.
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    tick(10);
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        tick(LATENCY - 1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
      end
    join
    tick(5);
    check("t5_data", data_o, 8'h22);
    check("t5_valid", valid_o, 1'b1);
    check("t5_no_ovr", ovr_cnt - o0, 0);
    ready = 1'b1;
    tick(2);

    // Reset in the middle of 0x3C, then a fresh byte.
    begin : t6_partial
      frame_t f;
      rx        = 1'b0;
      f.due     = cyc + LATENCY;
      f.data    = 8'h3C;
      f.ok      = 1'b1;
      f.pbad    = 1'b0;
      pend.push_back(f);
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
        rx = f.data[i];
        tick(CPB);
      end
    end
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(2);
    check("t6_reset_vec", dut_vec, 12'h000);
    check("t6_reset_busy", busy_o, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    r0 = rise_cnt; p0 = perr_cnt;
`ifdef UART_RX_PARITY_EN
    send_frame(8'h7E, 1'b1, 1'b1);
`else
    send_frame(8'h7E, 1'b1, 1'b0);
`endif
    tick(10);
    check("t6_data", data_o, 8'h7E);
    check("t6_one_delivery", rise_cnt - r0, 1);
`ifdef UART_RX_PARITY_EN
    check("t6_parity_pulses", perr_cnt - p0, 1);
`else
    check("t6_no_parity", perr_cnt - p0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
